// File: rtl/data_sram_axi_resp_pkg.sv
// Shared types and AXI constants for the data-SRAM to AXI4 responder.
package data_sram_axi_resp_pkg;

  localparam int unsigned ID_W = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_1B    = 3'd0;
  localparam logic [2:0] SIZE_2B    = 3'd1;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

endpackage

// File: rtl/axi_size_dec.sv
// Maps a byte-lane select to an AXI transfer size and the address to present.
module axi_size_dec
  import data_sram_axi_resp_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  output logic [2:0]  size,
  output logic [31:0] addr_aligned
);

  always_comb begin
    size = SIZE_4B;
    case (sel)
      4'b1111:                            size = SIZE_4B;
      4'b0011, 4'b1100:                   size = SIZE_2B;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_1B;
      // irregular lane patterns travel as a full word with a sparse strobe
      default:                            size = SIZE_4B;
    endcase
  end

  always_comb begin
    addr_aligned = addr;
    if (size == SIZE_4B) addr_aligned = {addr[31:2], 2'b00};
  end

endmodule

// File: rtl/data_sram_axi_resp.sv
// Turns each EX-stage data-SRAM request into one single-beat AXI4 read or write,
// stalling the pipeline until the response arrives.
module data_sram_axi_resp
  import data_sram_axi_resp_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic [2:0]  size_q;
  logic        aw_done;
  logic        w_done;
  logic [2:0]  dec_size;
  logic [31:0] dec_addr;
  logic        aw_hs;
  logic        w_hs;
  logic        unused_ok;

  // decoding the live request and registering the result gives the same
  // values as decoding the latched sel, without a decoder on the output path
  axi_size_dec u_size_dec (
    .sel          (req_sel),
    .addr         (req_addr),
    .size         (dec_size),
    .addr_aligned (dec_addr)
  );

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      size_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_en) begin
          addr_q  <= dec_addr;
          size_q  <= dec_size;
          sel_q   <= req_sel;
          wdata_q <= req_wdata;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (req_we) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= WR_REQ;
          end else begin
            arvalid <= 1'b1;
            state   <= RD_ADDR;
          end
        end
        RD_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= RD_DATA;
        end
        RD_DATA: if (rvalid) begin
          rready    <= 1'b0;
          rsp_rdata <= rdata;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: if (bvalid) begin
          bready    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = ((state == IDLE) && req_en) || ((state != IDLE) && (state != DONE));

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = '0;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = sel_q;
  assign wlast   = 1'b1;

  // response IDs and status are deliberately ignored
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_data_sram_axi_resp.sv
// Randomised scoreboard bench for data_sram_axi_resp with a delay-configurable AXI slave.
module tb_data_sram_axi_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en, req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  data_sram_axi_resp #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ar     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  typedef struct { logic [31:0] addr; logic [2:0] size; } addr_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
  typedef struct { logic we; logic [31:0] rdata; } rsp_exp_t;

  addr_exp_t ar_q[$];
  addr_exp_t aw_q[$];
  w_exp_t    w_q[$];
  rsp_exp_t  rsp_q[$];

  bit [31:0] mem [bit [31:0]];

  // slave read data: explicit contents, else a fixed scramble of the address
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    bit [31:0] k;
    k = a;
    if (mem.exists(k)) return mem[k];
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
  endfunction

  function automatic logic [2:0] model_size(input logic [3:0] s);
    if ($countones(s) == 1) return 3'd0;
    if (s == 4'b0011 || s == 4'b1100) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] s);
    if (model_size(s) == 3'd2) return {a[31:2], 2'b00};
    return a;
  endfunction

  // slave: each ready/valid appears a set number of cycles after it could
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit rd_pend, aw_got, w_got, wr_pend;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, arv, awv, wv;
    logic [31:0] rd_addr, a_cap;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_pend = 0; aw_got = 0; w_got = 0; wr_pend = 0; rd_addr = '0;
    arready = 0; rvalid = 0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b1;
    awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      arv = arvalid; awv = awvalid; wv = wvalid; a_cap = araddr;
      @(posedge clk);
      #1;
      if (!rst) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; wr_pend = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        continue;
      end
      if (ar_hs) ar_cnt = 0; else if (arv) ar_cnt++;
      if (r_hs) rd_pend = 0;
      else if (ar_hs) begin rd_pend = 1; rd_addr = a_cap; r_cnt = 0; end
      else if (rd_pend) r_cnt++;
      if (aw_hs) begin aw_got = 1; aw_cnt = 0; end else if (awv) aw_cnt++;
      if (w_hs) begin w_got = 1; w_cnt = 0; end else if (wv) w_cnt++;
      if (b_hs) wr_pend = 0;
      else if (aw_got && w_got) begin wr_pend = 1; aw_got = 0; w_got = 0; b_cnt = 0; end
      else if (wr_pend) b_cnt++;
      arready = arvalid && (ar_cnt >= ar_dly);
      awready = awvalid && (aw_cnt >= aw_dly);
      wready  = wvalid && (w_cnt >= w_dly);
      rvalid  = rd_pend && (r_cnt >= r_dly);
      bvalid  = wr_pend && (b_cnt >= b_dly);
      rdata   = rvalid ? rd_model(rd_addr) : $urandom;
      rid = 4'($urandom); rresp = 2'($urandom); bid = 4'($urandom); bresp = 2'($urandom);
    end
  end

  // monitor: pops expectations on every handshake / response
  initial begin
    addr_exp_t ea;
    w_exp_t    ew;
    rsp_exp_t  er;
    bit p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    p_arv = 0; p_arhs = 0; p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_arv = 0; p_awv = 0; p_wv = 0;
        continue;
      end
      if (p_arv && !p_arhs) begin
        check("arvalid_hold", 32'(arvalid), 32'd1);
        check("araddr_hold", araddr, p_araddr);
      end
      if (p_awv && !p_awhs) begin
        check("awvalid_hold", 32'(awvalid), 32'd1);
        check("awaddr_hold", awaddr, p_awaddr);
      end
      if (p_wv && !p_whs) begin
        check("wvalid_hold", 32'(wvalid), 32'd1);
        check("wdata_hold", wdata, p_wdata);
        check("wstrb_hold", 32'(wstrb), 32'(p_wstrb));
      end
      if (arvalid && arready) begin
        n_ar++;
        if (ar_q.size() == 0) fail_now("ar_unexpected");
        else begin
          ea = ar_q.pop_front();
          check("araddr", araddr, ea.addr);
          check("arsize", 32'(arsize), 32'(ea.size));
          check("ar_fixed", {12'h0, arid, arlen, 6'h0, arburst}, {12'h0, 4'd1, 8'd0, 6'h0, 2'b01});
        end
      end
      if (awvalid && awready) begin
        if (aw_q.size() == 0) fail_now("aw_unexpected");
        else begin
          ea = aw_q.pop_front();
          check("awaddr", awaddr, ea.addr);
          check("awsize", 32'(awsize), 32'(ea.size));
          check("aw_fixed", {12'h0, awid, awlen, 6'h0, awburst}, {12'h0, 4'd1, 8'd0, 6'h0, 2'b01});
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) fail_now("w_unexpected");
        else begin
          ew = w_q.pop_front();
          check("wdata", wdata, ew.data);
          check("wstrb", 32'(wstrb), 32'(ew.strb));
          check("w_fixed", {27'h0, wid, wlast}, {27'h0, 4'd1, 1'b1});
        end
      end
      if (rsp_valid) begin
        check("tie_offs", 32'({arlock, awlock, arcache, awcache, arprot, awprot}), 32'd0);
        if (rsp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          er = rsp_q.pop_front();
          if (!er.we) check("rsp_rdata", rsp_rdata, er.rdata);
        end
      end
      p_arv = arvalid; p_arhs = arvalid && arready; p_araddr = araddr;
      p_awv = awvalid; p_awhs = awvalid && awready; p_awaddr = awaddr;
      p_wv = wvalid; p_whs = wvalid && wready; p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  logic tr_arv[32], tr_awv[32], tr_wv[32], tr_br[32];

  // issue one request (called just after a rising edge) and wait for its response
  task automatic do_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold, output int lat);
    addr_exp_t ea;
    w_exp_t    ew;
    rsp_exp_t  er;
    int stalls, exp_lat;
    req_en = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wd;
    ea.addr = model_addr(addr, sel);
    ea.size = model_size(sel);
    er.we = we;
    er.rdata = '0;
    if (we) begin
      ew.data = wd; ew.strb = sel;
      aw_q.push_back(ea);
      w_q.push_back(ew);
      exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    end else begin
      er.rdata = rd_model(ea.addr);
      ar_q.push_back(ea);
      exp_lat = 3 + ar_dly + r_dly;
    end
    rsp_q.push_back(er);
    for (int i = 0; i < 32; i++) begin
      tr_arv[i] = 0; tr_awv[i] = 0; tr_wv[i] = 0; tr_br[i] = 0;
    end
    lat = 0;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (lat < 32) begin
        tr_arv[lat] = arvalid; tr_awv[lat] = awvalid; tr_wv[lat] = wvalid; tr_br[lat] = bready;
      end
      if (rsp_valid) break;
      if (stall) stalls++;
      lat++;
      if (lat > 200) begin
        fail_now("rsp_timeout");
        break;
      end
    end
    if (lat <= 200) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("stall_cycles", 32'(stalls), 32'(lat));
      check("stall_in_done", 32'(stall), 32'd0);
    end
    @(posedge clk);
    #1;
    if (!hold) req_en = 1'b0;
  endtask

  task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  initial begin
    int lat, ar_before, cyc;
    bit ok;
    rst = 1'b0; req_en = 1'b0; req_we = 1'b0; req_sel = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready, rsp_valid}), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_stall_idle", 32'(stall), 32'd0);
    req_en = 1'b1;
    #1;
    check("rst_stall_req", 32'(stall), 32'd1);
    req_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    set_dly(0, 0, 0, 0, 0);
    mem[32'h1000_0004] = 32'hDEADBEEF;
    do_req(1'b0, 4'b1111, 32'h1000_0004, 32'h0, 1'b0, lat);
    check("load_word_lat", 32'(lat), 32'd3);

    do_req(1'b1, 4'b0100, 32'h2000_0002, 32'h00AB_0000, 1'b0, lat);
    check("store_byte_lat", 32'(lat), 32'd3);
    check("rsp_single", 32'(rsp_valid), 32'd0);
    check("rdata_held", rsp_rdata, 32'hDEADBEEF);

    set_dly(0, 0, 4, 0, 0);
    do_req(1'b1, 4'b1111, 32'h4000_0008, 32'h1234_5678, 1'b0, lat);
    check("skew_both_c1", 32'({tr_awv[1], tr_wv[1]}), 32'b11);
    check("skew_w_drop_c2", 32'({tr_awv[2], tr_wv[2]}), 32'b10);
    check("skew_aw_c5", 32'({tr_awv[5], tr_br[5]}), 32'b10);
    check("skew_bready_c6", 32'({tr_awv[6], tr_br[6]}), 32'b01);

    set_dly(0, 0, 0, 0, 0);
    ar_before = n_ar;
    do_req(1'b0, 4'b1111, 32'h5000_0010, 32'h0, 1'b1, lat);
    do_req(1'b0, 4'b0011, 32'h5000_0022, 32'h0, 1'b0, lat);
    check("b2b_idle_gap", 32'({tr_arv[0], tr_arv[1]}), 32'b01);
    check("b2b_ar_count", 32'(n_ar - ar_before), 32'd2);

    do_req(1'b1, 4'b0111, 32'h3000_0001, 32'hCAFE_F00D, 1'b0, lat);

    // reset while the read data phase is waiting on the slave
    set_dly(0, 50, 0, 0, 0);
    req_en = 1'b1; req_we = 1'b0; req_sel = 4'b1111; req_addr = 32'h6000_0000;
    begin
      addr_exp_t ea;
      rsp_exp_t er;
      ea.addr = 32'h6000_0000; ea.size = 3'd2;
      er.we = 1'b0; er.rdata = '0;
      ar_q.push_back(ea);
      rsp_q.push_back(er);
    end
    ok = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (rready) begin ok = 1; break; end
    end
    if (!ok) fail_now("reach_rd_data");
    #1;
    req_en = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mid_valids", 32'({arvalid, rready, awvalid, wvalid, bready, rsp_valid}), 32'd0);
    check("rst_mid_idle", 32'(stall), 32'd0);
    rsp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_dly(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_req(1'b0, 4'b1000, 32'h6000_0003, 32'h0, 1'b0, lat);
    check("post_rst_lat", 32'(lat), 32'd3);

    for (int i = 0; i < 40; i++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
             (i != 39) && ($urandom_range(0, 1) == 1), lat);
    end

    repeat (4) @(negedge clk);
    check("queues_empty", 32'(ar_q.size() + aw_q.size() + w_q.size() + rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
